// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register-index/data widths and the write-back result payload.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NREG      = 8;

    // One completed result travelling from execute/memory to the regfile write port
    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Result FIFO for the write-back stage; pointers carry an extra MSB to tell full from empty.
module wb_result_fifo
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    // Pointer advance on push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are don't-care until the write pointer covers them
    always_ff @(posedge clk) begin
        if (push_i && !rst) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: buffers results, drains one per cycle to the regfile write port,
// and tracks pending writes per register for RAW stalls.
// Optional feature macro: WB_BYPASS_EN (write-cycle bypass to the read stage).
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid,
    input  logic                 iss_wb,
    input  logic [REG_IDX_W-1:0] iss_dst,
    output logic                 iss_stall,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic                 res_we,
    input  logic [REG_IDX_W-1:0] res_dst,
    input  logic [DATA_W-1:0]    res_data,
    input  logic                 wb_hold,
    output logic                 we,
    output logic [REG_IDX_W-1:0] widx,
    output logic [DATA_W-1:0]    wdata,
    output logic [NREG-1:0]      busy,
    input  logic [REG_IDX_W-1:0] src1_idx,
    input  logic [REG_IDX_W-1:0] src2_idx,
    output logic                 byp_hit1,
    output logic                 byp_hit2,
    output logic [DATA_W-1:0]    byp_val1,
    output logic [DATA_W-1:0]    byp_val2
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t            in_entry;
    wb_entry_t            fifo_head;
    wb_entry_t            pop_entry;
    logic                 fifo_full, fifo_empty;
    logic                 push, drain, fifo_push, fifo_pop;

    logic                 we_q, we_d;
    logic [REG_IDX_W-1:0] widx_q, widx_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic [CNT_W-1:0]     cnt_q [NREG];
    logic [CNT_W-1:0]     cnt_d [NREG];
    logic [NREG-1:0]      inc_vec, dec_vec;
    logic                 iss_inc;

    assign in_entry  = '{we: res_we, dst: res_dst, data: res_data};
    assign res_ready = !fifo_full;
    assign push      = res_valid && res_ready;

    // Drain whenever something is available after this cycle's push; an empty FIFO is bypassed
    assign drain     = !wb_hold && (!fifo_empty || push);
    assign fifo_pop  = drain && !fifo_empty;
    assign fifo_push = push && !(drain && fifo_empty);
    assign pop_entry = fifo_empty ? in_entry : fifo_head;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (in_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next write-port values: one-cycle we per popped entry, index/data held otherwise
    always_comb begin
        we_d    = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        if (drain) begin
            we_d = pop_entry.we;
            if (pop_entry.we) begin
                widx_d  = pop_entry.dst;
                wdata_d = pop_entry.data;
            end
        end
    end

    // Write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign widx  = widx_q;
    assign wdata = wdata_q;

    assign iss_stall = (cnt_q[iss_dst] == CNT_MAX);
    assign iss_inc   = iss_valid && iss_wb && !iss_stall;

    // Per-register increment (issue) and decrement (commit); decrement at zero is dropped
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            inc_vec[i] = iss_inc && (iss_dst == REG_IDX_W'(i));
            dec_vec[i] = we_q && (widx_q == REG_IDX_W'(i)) && (cnt_q[i] != '0);
        end
    end

    // Scoreboard next state; simultaneous inc and dec cancel
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (dec_vec[i] && !inc_vec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef WB_BYPASS_EN
    // Busy view: the last pending write is visible on the bypass during its write cycle
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy[i] = (cnt_q[i] != '0) &&
                      !(we_q && (widx_q == REG_IDX_W'(i)) && (cnt_q[i] == CNT_W'(1)));
        end
    end

    assign byp_hit1 = we_q && (widx_q == src1_idx);
    assign byp_hit2 = we_q && (widx_q == src2_idx);
    assign byp_val1 = wdata_q;
    assign byp_val2 = wdata_q;
`else
    // Busy view: a register stays busy until its commit edge has passed
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    logic unused_src;
    assign unused_src = ^{src1_idx, src2_idx};

    assign byp_hit1 = 1'b0;
    assign byp_hit2 = 1'b0;
    assign byp_val1 = '0;
    assign byp_val2 = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed table, hand sequences, random vs queue model.
module tb_writeback_stage;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH   = 2;
    localparam int          CNT_MAX = 3;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_wb;
    logic [2:0]  iss_dst;
    logic        iss_stall;
    logic        res_valid, res_ready, res_we;
    logic [2:0]  res_dst;
    logic [31:0] res_data;
    logic        wb_hold;
    logic        we;
    logic [2:0]  widx;
    logic [31:0] wdata;
    logic [7:0]  busy;
    logic [2:0]  src1_idx, src2_idx;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_val1, byp_val2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    writeback_stage #(.DEPTH(DEPTH), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_wb(iss_wb), .iss_dst(iss_dst), .iss_stall(iss_stall),
        .res_valid(res_valid), .res_ready(res_ready), .res_we(res_we),
        .res_dst(res_dst), .res_data(res_data), .wb_hold(wb_hold),
        .we(we), .widx(widx), .wdata(wdata), .busy(busy),
        .src1_idx(src1_idx), .src2_idx(src2_idx),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_val1(byp_val1), .byp_val2(byp_val2)
    );

    // Shadow register file fed by the write port
    logic [31:0] rf_sh [8];
    always @(posedge clk) if (we === 1'b1) rf_sh[widx] <= wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; iss_valid = 1'b0; iss_wb = 1'b0; iss_dst = '0;
        res_valid = 1'b0; res_we = 1'b0; res_dst = '0; res_data = '0;
        wb_hold = 1'b0; src1_idx = '0; src2_idx = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Directed vector: inputs for one cycle and outputs expected after the edge
    typedef struct {
        logic        iss_v;
        logic [2:0]  iss_d;
        logic        rv, rwe;
        logic [2:0]  rd;
        logic [31:0] rdata;
        logic        hold;
        logic        e_we;
        logic [2:0]  e_widx;
        logic [31:0] e_wdata;
        logic [7:0]  e_busy;
        logic        e_ready;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [2:0] id, input logic rv, input logic rwe,
                                input logic [2:0] rd, input logic [31:0] rdata, input logic hold,
                                input logic ewe, input logic [2:0] ewidx, input logic [31:0] ewdata,
                                input logic [7:0] ebusy, input logic erdy);
        vec_t v;
        v.iss_v = iv; v.iss_d = id; v.rv = rv; v.rwe = rwe; v.rd = rd; v.rdata = rdata;
        v.hold = hold; v.e_we = ewe; v.e_widx = ewidx; v.e_wdata = ewdata;
        v.e_busy = ebusy; v.e_ready = erdy;
        return v;
    endfunction

    // Behavioural reference: a queue of results plus integer pending counts
    wb_entry_t   mq[$];
    int          mcnt [8];
    bit          m_we;
    logic [2:0]  m_widx;
    logic [31:0] m_wdata;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        m_we = 1'b0; m_widx = '0; m_wdata = '0;
    endtask

    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = (mcnt[i] != 0) && !(BYP && m_we && (int'(m_widx) == i) && (mcnt[i] == 1));
        return b;
    endfunction

    // Advance the model by one edge using the inputs currently applied
    task automatic model_step();
        bit        acc, inc, dec;
        wb_entry_t e;
        if (rst) begin
            model_reset();
            return;
        end
        acc = res_valid && (mq.size() < DEPTH);
        inc = iss_valid && iss_wb && (mcnt[iss_dst] < CNT_MAX);
        dec = m_we && (mcnt[m_widx] > 0);
        if (inc) mcnt[iss_dst]++;
        if (dec) mcnt[m_widx]--;
        if (acc) begin
            e.we = res_we; e.dst = res_dst; e.data = res_data;
            mq.push_back(e);
        end
        m_we = 1'b0;
        if (!wb_hold && mq.size() > 0) begin
            e = mq.pop_front();
            m_we = e.we;
            if (e.we) begin
                m_widx  = e.dst;
                m_wdata = e.data;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];

        idle();
        #1;
        reset_dut();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_widx", 32'(widx), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_byp1", 32'(byp_hit1), 32'd0);

        // Single write, two writes to one register, full FIFO under hold
        tbl[0]  = mk(0, 0, 1, 1, 3, 32'hDEADBEEF, 0, 1, 3, 32'hDEADBEEF, 8'h00, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        8'h00, 1);
        tbl[2]  = mk(1, 5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        8'h20, 1);
        tbl[3]  = mk(1, 5, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        8'h20, 1);
        tbl[4]  = mk(0, 0, 1, 1, 5, 32'h11,       0, 1, 5, 32'h11,       8'h20, 1);
        tbl[5]  = mk(0, 0, 1, 1, 5, 32'h22,       0, 1, 5, 32'h22,       BYP ? 8'h00 : 8'h20, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        8'h00, 1);
        tbl[7]  = mk(0, 0, 1, 1, 1, 32'hA1,       1, 0, 0, 32'h0,        8'h00, 1);
        tbl[8]  = mk(0, 0, 1, 1, 2, 32'hA2,       1, 0, 0, 32'h0,        8'h00, 0);
        tbl[9]  = mk(0, 0, 1, 1, 3, 32'hA3,       1, 0, 0, 32'h0,        8'h00, 0);
        tbl[10] = mk(0, 0, 1, 1, 3, 32'hA3,       0, 1, 1, 32'hA1,       8'h00, 1);
        tbl[11] = mk(0, 0, 1, 1, 3, 32'hA3,       0, 1, 2, 32'hA2,       8'h00, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        0, 1, 3, 32'hA3,       8'h00, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        8'h00, 1);

        for (int i = 0; i < 14; i++) begin
            idle();
            iss_valid = tbl[i].iss_v; iss_wb = tbl[i].iss_v; iss_dst = tbl[i].iss_d;
            res_valid = tbl[i].rv; res_we = tbl[i].rwe; res_dst = tbl[i].rd;
            res_data = tbl[i].rdata; wb_hold = tbl[i].hold;
            step();
            chk($sformatf("tbl%0d_we", i), 32'(we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d_widx", i), 32'(widx), 32'(tbl[i].e_widx));
                chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].e_wdata);
            end
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_ready", i), 32'(res_ready), 32'(tbl[i].e_ready));
        end
        chk("rf_r5", rf_sh[5], 32'h22);
        chk("rf_r1", rf_sh[1], 32'hA1);
        chk("rf_r3", rf_sh[3], 32'hA3);

        // Issue and commit to the same register on one edge, then saturation
        reset_dut();
        iss_valid = 1; iss_wb = 1; iss_dst = 2; step(); idle();
        res_valid = 1; res_we = 1; res_dst = 2; res_data = 32'h5; step(); idle();
        chk("same_we", 32'(we), 32'd1);
        chk("same_widx", 32'(widx), 32'd2);
        iss_valid = 1; iss_wb = 1; iss_dst = 2; step(); idle();
        chk("same_busy2", 32'(busy[2]), 32'd1);
        step();
        chk("same_busy2_hold", 32'(busy[2]), 32'd1);
        iss_valid = 1; iss_wb = 1; iss_dst = 2; step();
        step();
        #1;
        chk("sat_stall", 32'(iss_stall), 32'd1);
        step();
        iss_dst = 6; #1;
        chk("sat_other", 32'(iss_stall), 32'd0);
        iss_dst = 2; #1;
        chk("sat_stall_kept", 32'(iss_stall), 32'd1);
        idle();

        // Reset with results queued and a pending count
        reset_dut();
        iss_valid = 1; iss_wb = 1; iss_dst = 1; step(); idle();
        wb_hold = 1; res_valid = 1; res_we = 1; res_dst = 1; res_data = 32'h77; step();
        res_data = 32'h78; step();
        chk("q_ready", 32'(res_ready), 32'd0);
        chk("q_busy1", 32'(busy[1]), 32'd1);
        rst = 1; wb_hold = 0; res_data = 32'h79; iss_valid = 1; iss_wb = 1; iss_dst = 1;
        step(); idle();
        chk("mrst_we", 32'(we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(res_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mrst_nowrite%0d", i), 32'(we), 32'd0);
        end

        // Bypass on the write cycle
        reset_dut();
        res_valid = 1; res_we = 1; res_dst = 4; res_data = 32'h44; step(); idle();
        src1_idx = 4; src2_idx = 5; #1;
        chk("byp_hit1", 32'(byp_hit1), 32'(BYP));
        chk("byp_val1", byp_val1, BYP ? 32'h44 : 32'h0);
        chk("byp_hit2", 32'(byp_hit2), 32'd0);
        chk("byp_val2", byp_val2, BYP ? 32'h44 : 32'h0);
        idle();

        // Randomized traffic against the queue model
        reset_dut();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_wb    = ($urandom_range(0, 3) != 0);
            iss_dst   = 3'($urandom_range(0, 7));
            res_valid = ($urandom_range(0, 9) < 6);
            res_we    = ($urandom_range(0, 4) != 0);
            res_dst   = 3'($urandom_range(0, 7));
            res_data  = $urandom;
            wb_hold   = ($urandom_range(0, 3) == 0);
            src1_idx  = 3'($urandom_range(0, 7));
            src2_idx  = 3'($urandom_range(0, 7));
            #1;
            chk("rnd_ready", 32'(res_ready), 32'(mq.size() < DEPTH));
            chk("rnd_stall", 32'(iss_stall), 32'(mcnt[iss_dst] == CNT_MAX));
            chk("rnd_busy", 32'(busy), 32'(model_busy()));
            chk("rnd_we", 32'(we), 32'(m_we));
            if (m_we) begin
                chk("rnd_widx", 32'(widx), 32'(m_widx));
                chk("rnd_wdata", wdata, m_wdata);
            end
            chk("rnd_byp1", 32'(byp_hit1), 32'(BYP && m_we && (m_widx == src1_idx)));
            chk("rnd_byp2", 32'(byp_hit2), 32'(BYP && m_we && (m_widx == src2_idx)));
            @(posedge clk);
            model_step();
            #1;
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
